// File: rtl/stdp_array_if.sv
// Spike, learning-control, weight-load and observation signals of the STDP engine.
// The driver of spikes and loads takes master; the STDP engine takes slave.
interface stdp_array_if #(
  parameter int N   = 4,
  parameter int T_W = 4,
  parameter int W_W = 4
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic               learn_en;
  logic [N-1:0]       pre_spike;
  logic               post_spike;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [W_W-1:0]     wr_data;
  logic [N*W_W-1:0]   weight;
  logic [N*T_W-1:0]   last_dt;
  logic [N-1:0]       ltp_mask;
  logic [N-1:0]       ltd_mask;
  logic               update_w_flag;

  modport master (
    output learn_en, pre_spike, post_spike, wr_en, wr_idx, wr_data,
    input  weight, last_dt, ltp_mask, ltd_mask, update_w_flag
  );

  modport slave (
    input  learn_en, pre_spike, post_spike, wr_en, wr_idx, wr_data,
    output weight, last_dt, ltp_mask, ltd_mask, update_w_flag
  );
endinterface

// File: rtl/stdp_array.sv
// STDP engine: per-channel spike timers, windowed shift-kernel LTP/LTD on saturating weights,
// host weight loads; all outputs update at the sampling edge. Optional decay: STDP_WEIGHT_DECAY_EN.
module stdp_array #(
  parameter int N            = 4,
  parameter int T_W          = 4,
  parameter int W_W          = 4,
  parameter int W_INIT       = 8,
  parameter int W_MAX        = 15,
  parameter int A_PLUS       = 8,
  parameter int A_MINUS      = 4,
  parameter int TAU_SHIFT    = 1,
  parameter int WINDOW       = 12,
  parameter int DECAY_PERIOD = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  stdp_array_if.slave    bus
);
  localparam int             IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [T_W-1:0] STALE = '1;
  localparam logic [T_W-1:0] WIN   = T_W'(WINDOW);
  localparam logic [W_W-1:0] WMAX  = W_W'(W_MAX);
  localparam logic [W_W-1:0] WINIT = W_W'(W_INIT);
  localparam logic [W_W:0]   AP    = (W_W+1)'(A_PLUS);
  localparam logic [W_W:0]   AM    = (W_W+1)'(A_MINUS);

  logic [N*T_W-1:0] r_pre_t;
  logic [T_W-1:0]   r_post_t;
  logic [N*W_W-1:0] r_weight;
  logic [N*T_W-1:0] r_last_dt;
  logic [N-1:0]     r_ltp_mask;
  logic [N-1:0]     r_ltd_mask;
  logic             r_flag;

  logic [N*T_W-1:0] w_pre_t_nxt;
  logic [T_W-1:0]   w_post_t_nxt;
  logic [N*W_W-1:0] w_weight_nxt;
  logic [N*T_W-1:0] w_last_dt_nxt;
  logic [N-1:0]     w_ltp_mask;
  logic [N-1:0]     w_ltd_mask;
  logic [W_W-1:0]   w_wr_clamped;
  logic             w_decay_tick;

  assign w_wr_clamped = (bus.wr_data > WMAX) ? WMAX : bus.wr_data;
  assign w_post_t_nxt = bus.post_spike ? T_W'(1)
                      : ((r_post_t == STALE) ? r_post_t : r_post_t + T_W'(1));

`ifdef STDP_WEIGHT_DECAY_EN
  localparam int CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [CNT_W-1:0] r_decay_cnt;

  assign w_decay_tick = (r_decay_cnt == CNT_W'(DECAY_PERIOD - 1)) && bus.learn_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_decay_cnt <= '0;
    end else if (r_decay_cnt == CNT_W'(DECAY_PERIOD - 1)) begin
      r_decay_cnt <= '0;
    end else begin
      r_decay_cnt <= r_decay_cnt + CNT_W'(1);
    end
  end
`else
  assign w_decay_tick = 1'b0;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [T_W-1:0] w_pre_t;
    logic [W_W-1:0] w_w;
    logic [T_W-1:0] w_ltp_dt;
    logic [W_W:0]   w_dp;
    logic [W_W:0]   w_dm;
    logic [W_W:0]   w_sum;
    logic [W_W:0]   w_diff;
    logic [W_W-1:0] w_sum_sat;
    logic [W_W-1:0] w_diff_sat;
    logic [W_W-1:0] w_decayed;
    logic           w_ltp_hit;
    logic           w_ltd_hit;
    logic           w_wr_hit;

    assign w_pre_t  = r_pre_t[gi*T_W +: T_W];
    assign w_w      = r_weight[gi*W_W +: W_W];
    // A pre spike coinciding with the post spike counts as dt = 0, not the stale/old timer.
    assign w_ltp_dt = bus.pre_spike[gi] ? '0 : w_pre_t;

    assign w_ltp_hit = bus.learn_en && bus.post_spike && (w_ltp_dt < WIN);
    assign w_ltd_hit = bus.learn_en && bus.pre_spike[gi] && !bus.post_spike && (r_post_t < WIN);
    assign w_wr_hit  = bus.wr_en && (bus.wr_idx == IDX_W'(gi));

    assign w_dp       = AP >> (w_ltp_dt >> TAU_SHIFT);
    assign w_dm       = AM >> (r_post_t >> TAU_SHIFT);
    assign w_sum      = {1'b0, w_w} + w_dp;
    assign w_diff     = {1'b0, w_w} - w_dm;
    assign w_sum_sat  = (w_sum > {1'b0, WMAX}) ? WMAX : w_sum[W_W-1:0];
    assign w_diff_sat = (w_dm > {1'b0, w_w}) ? '0 : w_diff[W_W-1:0];
    assign w_decayed  = (w_decay_tick && (w_w != '0)) ? w_w - W_W'(1) : w_w;

    assign w_ltp_mask[gi] = w_ltp_hit && !w_wr_hit;
    assign w_ltd_mask[gi] = w_ltd_hit && !w_wr_hit;

    assign w_weight_nxt[gi*W_W +: W_W] = w_wr_hit  ? w_wr_clamped
                                       : w_ltp_hit ? w_sum_sat
                                       : w_ltd_hit ? w_diff_sat
                                       : w_decayed;

    assign w_last_dt_nxt[gi*T_W +: T_W] = w_ltp_mask[gi] ? w_ltp_dt : r_last_dt[gi*T_W +: T_W];

    assign w_pre_t_nxt[gi*T_W +: T_W] = bus.pre_spike[gi] ? T_W'(1)
                                      : ((w_pre_t == STALE) ? w_pre_t : w_pre_t + T_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_t    <= {N{STALE}};
      r_post_t   <= STALE;
      r_weight   <= {N{WINIT}};
      r_last_dt  <= '0;
      r_ltp_mask <= '0;
      r_ltd_mask <= '0;
      r_flag     <= 1'b0;
    end else begin
      r_pre_t    <= w_pre_t_nxt;
      r_post_t   <= w_post_t_nxt;
      r_weight   <= w_weight_nxt;
      r_last_dt  <= w_last_dt_nxt;
      r_ltp_mask <= w_ltp_mask;
      r_ltd_mask <= w_ltd_mask;
      r_flag     <= |{w_ltp_mask, w_ltd_mask};
    end
  end

  assign bus.weight        = r_weight;
  assign bus.last_dt       = r_last_dt;
  assign bus.ltp_mask      = r_ltp_mask;
  assign bus.ltd_mask      = r_ltd_mask;
  assign bus.update_w_flag = r_flag;
endmodule

// File: doc/stdp_array.md
Name: stdp_array

Overview:
- Parametrised spike-timing-dependent plasticity (STDP) engine for N presynaptic channels and one postsynaptic neuron.
- Tracks per-channel spike timers and applies windowed potentiation (LTP) and depression (LTD) to saturating weight registers.
- Weight deltas follow a shift-based exponential kernel.
- Sits between the spike sources and the neuron integrator, which reads the weight vector.
- Weights are host-loadable through a write port.

Parameters:
- N, 4: number of presynaptic channels.
- T_W, 4: timer width in bits. Timer value 2^T_W-1 means "stale".
- W_W, 4: weight width in bits.
- W_INIT, 8: reset value of every weight.
- W_MAX, 15: upper weight bound. Must be ≤ 2^W_W-1.
- A_PLUS, 8: LTP base delta.
- A_MINUS, 4: LTD base delta.
- TAU_SHIFT, 1: kernel decay; delta = A >> (dt >> TAU_SHIFT).
- WINDOW, 12: updates apply only when dt < WINDOW. Must be ≤ 2^T_W-1.
- DECAY_PERIOD, 64: cycles between decay steps (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- learn_en  in  1  enables LTP/LTD. Timers always run.
- pre_spike  in  N  presynaptic spikes, one bit per channel.
- post_spike  in  1  postsynaptic spike.
- wr_en  in  1  weight load strobe.
- wr_idx  in  clog2(N)  channel to load.
- wr_data  in  W_W  load value. Clamped to W_MAX.
- weight  out  N*W_W  weights; channel i at bits [i*W_W +: W_W].
- last_dt  out  N*T_W  dt used by the most recent LTP per channel.
- ltp_mask  out  N  channels potentiated last cycle.
- ltd_mask  out  N  channels depressed last cycle.
- update_w_flag  out  1  pulse: any weight changed by learning last cycle.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values:
  - all pre timers and the post timer = 2^T_W-1 (stale);
  - weight = W_INIT for every channel;
  - last_dt = 0, ltp_mask = 0, ltd_mask = 0, update_w_flag = 0.
- A reset asserted mid-operation discards all pending effects in that cycle.
- Timers, per edge:
  - spike on the channel loads 1;
  - otherwise saturating increment, holding at 2^T_W-1.
  - A pre spike at edge k followed by a post spike at edge k+d therefore reads timer = d.
- dt definition:
  - LTP, channel i: dt = 0 if pre_spike[i] and post_spike share an edge, else pre_timer[i] (registered value).
  - LTD, channel i: dt = post_timer (registered value).
- LTP: post_spike & learn_en & dt < WINDOW gives w_i <= min(w_i + (A_PLUS >> (dt >> TAU_SHIFT)), W_MAX).
- LTD: pre_spike[i] & learn_en & !post_spike & post_timer < WINDOW gives w_i <= max(w_i - (A_MINUS >> (post_timer >> TAU_SHIFT)), 0).
  - Same-edge pre+post is LTP only.
- Arithmetic: computed at W_W+1 bits, then saturated. A zero delta still counts as an update (mask bit set).
- Latency: weights, masks, last_dt and update_w_flag all update at the edge that samples the spike.
  - Masks and flag are valid for exactly one cycle.
- Load: wr_en overrides learning for channel wr_idx in the same edge.
  - That channel's mask bits stay 0 and it does not contribute to update_w_flag.
  - Timers are unaffected.
- Out-of-range wr_idx (≥ N) is ignored.
- last_dt[i] updates only on an LTP to channel i.
- learn_en = 0: no weight change, masks 0, flag 0; loads still work.

Optional Feature:
- Macro: STDP_WEIGHT_DECAY_EN.
- When defined:
  - free-running counter, reset to 0;
  - when it reaches DECAY_PERIOD-1 it wraps, and if learn_en is set every weight not touched by learning or load in that edge decrements by 1, floor 0.
  - Decay does not set masks or update_w_flag.
- When undefined: no counter, and weights change only via LTP, LTD or load.

Test Plan:
- Reset with defaults → weight = 0x8888, masks 0, flag 0. Post spike with no prior pre → no change (timers stale).
- pre_spike = 0001 at edge k, post at k+3 → dt = 3, delta = 8>>1 = 4; w0 = 12, ltp_mask = 0001, last_dt[0] = 3, flag pulses one cycle.
- post at edge k, pre_spike = 0010 at k+2 → delta = 4>>1 = 2; w1 = 6, ltd_mask = 0010; no LTP.
- Two same-edge pre[3]+post events → delta 8 each; w3 = 15 after the first (saturated), still 15 after the second, ltp_mask bit3 set both times. Repeated LTD on a channel at 0 → stays 0.
- pre[0] then post 13 cycles later (dt = 13 ≥ WINDOW) → no change, flag 0.
- wr_en idx = 2, data = 3, on the same edge as post with pre[2] dt = 1 → w2 = 3, ltp_mask bit2 = 0. With STDP_WEIGHT_DECAY_EN, idle 64 cycles → all weights −1.
